hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the PC enable, the IF/ID register's IF_IDWrite and Branch (flush) inputs, the ID/EX hold/bubble controls and the EX/MEM bubble.
- Resolves load-use hazards, branch-operand hazards (branches resolve in ID), taken-branch flushes, and fixed-latency multiply/divide occupancy of EX.
- Keeps saturating stall and flush performance counters.

Parameters:
- MD_LATENCY, 4, total cycles a mul/div instruction occupies EX; legal range 2 to 15.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- IF_ID_Rs  input  5  rs field of the instruction in ID
- IF_ID_Rt  input  5  rt field of the instruction in ID
- IF_ID_UsesRt  input  1  ID instruction reads rt
- IF_ID_IsBranch  input  1  ID instruction is a conditional branch
- BranchTaken  input  1  branch in ID resolved taken this cycle
- ID_EX_WriteReg  input  5  destination register of the instruction in EX
- ID_EX_RegWrite  input  1  EX instruction writes a register
- ID_EX_MemRead  input  1  EX instruction is a load
- ID_EX_MulDiv  input  1  EX instruction is mul/div
- PCWrite  output  1  PC update enable
- IF_IDWrite  output  1  IF/ID write enable
- Branch  output  1  IF/ID flush; meaningful only together with IF_IDWrite=1
- ID_EXWrite  output  1  ID/EX write enable
- ID_EXBubble  output  1  zero the control fields written into ID/EX
- EX_MEMBubble  output  1  zero the control fields written into EX/MEM
- stall_cycles  output  CNT_W  cycles with PCWrite=0
- flush_count  output  CNT_W  cycles with Branch=1

Behaviour:
- Control outputs are combinational from the state and the inputs. The state, counter and performance registers are updated on the clk rising edge; reset clears them asynchronously.
- During reset and in the first cycle after it, the state is RUN and the counters are 0. While reset is high: PCWrite=0, IF_IDWrite=0, Branch=0, ID_EXWrite=0, ID_EXBubble=1, EX_MEMBubble=1.
- Defaults when no hazard is active: PCWrite=1, IF_IDWrite=1, ID_EXWrite=1, Branch=0, ID_EXBubble=0, EX_MEMBubble=0.
- Register-match term: dep = ID_EX_WriteReg!=0 and (ID_EX_WriteReg==IF_ID_Rs or (IF_ID_UsesRt and ID_EX_WriteReg==IF_ID_Rt)).
- States are RUN, BR_HOLD and MD_WAIT, plus a 4-bit md_cnt.
- RUN, evaluated in priority order; the first matching rule applies:
  - ID_EX_MulDiv: PCWrite=0, IF_IDWrite=0, ID_EXWrite=0, EX_MEMBubble=1; md_cnt<=MD_LATENCY-1; next state MD_WAIT.
  - ID_EX_MemRead and dep and IF_ID_IsBranch: PCWrite=0, IF_IDWrite=0, ID_EXBubble=1; next state BR_HOLD.
  - ID_EX_MemRead and dep: PCWrite=0, IF_IDWrite=0, ID_EXBubble=1; stay in RUN (one bubble).
  - IF_ID_IsBranch and ID_EX_RegWrite and dep: same outputs as the previous rule; stay in RUN.
  - BranchTaken: Branch=1 with IF_IDWrite=1 and PCWrite=1 (the PC loads the target and the fetched instruction is squashed).
- BR_HOLD lasts one cycle: PCWrite=0, IF_IDWrite=0, ID_EXBubble=1, BranchTaken is ignored; next state RUN.
- MD_WAIT:
  - While md_cnt>1: the same stall outputs as the RUN mul/div entry, and md_cnt decrements.
  - When md_cnt==1 (release cycle): ID_EXWrite=1, EX_MEMBubble=0, and the RUN rules apply with ID_EX_MulDiv masked; next state RUN.
  - Resulting EX residency is exactly MD_LATENCY cycles, of which MD_LATENCY-1 have PCWrite=0.
- BranchTaken in any stalled cycle is ignored. ID is frozen, so the branch is re-evaluated when the stall ends.
- Branch=1 never coincides with IF_IDWrite=0.
- A reset asserted mid-MD_WAIT or mid-BR_HOLD returns the block to RUN immediately and clears md_cnt.
- stall_cycles increments in every cycle with PCWrite=0 outside reset.
- flush_count increments in every cycle with Branch=1.
- Both counters saturate at 2^CNT_W-1 and do not wrap.

Test Plan:
- Load-use: a load into $5 in EX, with an add reading $5 as rs in ID. Required: exactly one cycle of PCWrite=0, IF_IDWrite=0, ID_EXBubble=1, then the defaults; stall_cycles=1.
- Load feeding a branch: a load into $3, with a beq reading $3 and BranchTaken=1. Required: two stall cycles (RUN then BR_HOLD) with Branch=0 in both, then one cycle with Branch=1; stall_cycles=2, flush_count=1.
- ALU feeding a branch: the EX instruction writes $4 and the ID instruction is a branch on $4. Required: one bubble. With IF_ID_UsesRt=0 and a rt match only, no stall. With ID_EX_WriteReg=0, no stall.
- Mul/div occupancy at MD_LATENCY=4: ID_EX_MulDiv=1. Required: 3 cycles of ID_EXWrite=0 and EX_MEMBubble=1, then a release cycle with ID_EXWrite=1; stall_cycles=3.
- Reset mid-stall: assert reset in the second MD_WAIT cycle. Required: outputs go to the reset values immediately. After release the state is RUN, the counters are 0, and PCWrite=1 given no hazard.
- Counter saturation (CNT_W=4): hold a continuous load-use stall for 20 cycles. Required: stall_cycles stops at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush sequencer with saturating perf counters
// Resolves load-use, branch-operand, taken-branch and mul/div occupancy hazards.
module hazard_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IF_ID_Rs,
  input  logic [4:0]       IF_ID_Rt,
  input  logic             IF_ID_UsesRt,
  input  logic             IF_ID_IsBranch,
  input  logic             BranchTaken,
  input  logic [4:0]       ID_EX_WriteReg,
  input  logic             ID_EX_RegWrite,
  input  logic             ID_EX_MemRead,
  input  logic             ID_EX_MulDiv,
  output logic             PCWrite,
  output logic             IF_IDWrite,
  output logic             Branch,
  output logic             ID_EXWrite,
  output logic             ID_EXBubble,
  output logic             EX_MEMBubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {RUN, BR_HOLD, MD_WAIT} state_t;

  localparam logic [3:0] MD_INIT = 4'(MD_LATENCY - 1);

  state_t     state, state_nxt;
  logic [3:0] md_cnt, md_cnt_nxt;
  logic       dep, md_entry, md_busy;

  assign dep = (ID_EX_WriteReg != 5'd0) &&
               ((ID_EX_WriteReg == IF_ID_Rs) ||
                (IF_ID_UsesRt && (ID_EX_WriteReg == IF_ID_Rt)));

  // The release cycle of MD_WAIT falls through to the RUN rules with MulDiv masked.
  assign md_entry = (state == RUN) && ID_EX_MulDiv;
  assign md_busy  = (state == MD_WAIT) && (md_cnt > 4'd1);

  always_comb begin
    PCWrite      = 1'b1;
    IF_IDWrite   = 1'b1;
    Branch       = 1'b0;
    ID_EXWrite   = 1'b1;
    ID_EXBubble  = 1'b0;
    EX_MEMBubble = 1'b0;
    state_nxt    = state;
    md_cnt_nxt   = md_cnt;
    if (reset) begin
      PCWrite      = 1'b0;
      IF_IDWrite   = 1'b0;
      ID_EXWrite   = 1'b0;
      ID_EXBubble  = 1'b1;
      EX_MEMBubble = 1'b1;
      state_nxt    = RUN;
      md_cnt_nxt   = 4'd0;
    end else if (state == BR_HOLD) begin
      PCWrite     = 1'b0;
      IF_IDWrite  = 1'b0;
      ID_EXBubble = 1'b1;
      state_nxt   = RUN;
    end else if (md_entry || md_busy) begin
      PCWrite      = 1'b0;
      IF_IDWrite   = 1'b0;
      ID_EXWrite   = 1'b0;
      EX_MEMBubble = 1'b1;
      md_cnt_nxt   = md_entry ? MD_INIT : (md_cnt - 4'd1);
      state_nxt    = MD_WAIT;
    end else begin
      state_nxt  = RUN;
      md_cnt_nxt = 4'd0;
      if (ID_EX_MemRead && dep) begin
        PCWrite     = 1'b0;
        IF_IDWrite  = 1'b0;
        ID_EXBubble = 1'b1;
        if (IF_ID_IsBranch) state_nxt = BR_HOLD;
      end else if (IF_ID_IsBranch && ID_EX_RegWrite && dep) begin
        PCWrite     = 1'b0;
        IF_IDWrite  = 1'b0;
        ID_EXBubble = 1'b1;
      end else if (BranchTaken) begin
        Branch = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      md_cnt       <= 4'd0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
      if (!PCWrite && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      if (Branch && (flush_count != '1)) flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - table vectors plus multi-cycle sequences for hazard_ctrl
// Expected control words are queued when driven and popped when sampled.
module tb_hazard_ctrl;

  localparam int CW = 4;

  localparam logic [5:0] DEF   = 6'b110100;
  localparam logic [5:0] STALL = 6'b000110;
  localparam logic [5:0] MD    = 6'b000001;
  localparam logic [5:0] FLUSH = 6'b111100;
  localparam logic [5:0] RST   = 6'b000011;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [4:0]    rs = '0, rt = '0, wreg = '0;
  logic          uses_rt = 0, is_br = 0, taken = 0, regw = 0, memrd = 0, muldiv = 0;
  logic          pcw, ifidw, br, idexw, idexb, exmemb;
  logic [CW-1:0] stall_cycles, flush_count;

  hazard_ctrl #(.MD_LATENCY(4), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .IF_ID_Rs(rs), .IF_ID_Rt(rt), .IF_ID_UsesRt(uses_rt),
    .IF_ID_IsBranch(is_br), .BranchTaken(taken),
    .ID_EX_WriteReg(wreg), .ID_EX_RegWrite(regw),
    .ID_EX_MemRead(memrd), .ID_EX_MulDiv(muldiv),
    .PCWrite(pcw), .IF_IDWrite(ifidw), .Branch(br),
    .ID_EXWrite(idexw), .ID_EXBubble(idexb), .EX_MEMBubble(exmemb),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       is_br;
    logic       taken;
    logic [4:0] wreg;
    logic       regw;
    logic       memrd;
    logic       muldiv;
  } in_t;

  typedef struct {
    in_t        in;
    logic [5:0] ctl;
    string      name;
  } vec_t;

  typedef struct {
    logic [5:0] ctl;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic in_t mk(input logic [4:0] a, input logic [4:0] b, input logic ur,
                             input logic ib, input logic tk, input logic [4:0] w,
                             input logic rw, input logic mr, input logic md);
    in_t v;
    v.rs = a; v.rt = b; v.uses_rt = ur; v.is_br = ib; v.taken = tk;
    v.wreg = w; v.regw = rw; v.memrd = mr; v.muldiv = md;
    return v;
  endfunction

  task automatic apply(input in_t v);
    rs = v.rs; rt = v.rt; uses_rt = v.uses_rt; is_br = v.is_br; taken = v.taken;
    wreg = v.wreg; regw = v.regw; memrd = v.memrd; muldiv = v.muldiv;
  endtask

  task automatic check_ctl();
    exp_t       e;
    logic [5:0] act;
    act = {pcw, ifidw, br, idexw, idexb, exmemb};
    n_vec++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: got %b with no expectation queued", act);
    end else begin
      e = sb.pop_front();
      if (act !== e.ctl) begin
        n_bad++;
        $display("FAIL %s: ctl got %b want %b", e.name, act, e.ctl);
      end
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step(input in_t v, input logic [5:0] ctl, input string name);
    apply(v);
    sb.push_back('{ctl, name});
    @(negedge clk);
    check_ctl();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string name);
    apply('0);
    reset = 1'b1;
    #1;
    sb.push_back('{RST, name});
    check_ctl();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  vec_t vt[$];
  in_t  idle, lu;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  initial begin
    idle = '0;
    lu   = mk(5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);

    //           rs     rt     ur    br    tk    wreg   rw    mr    md
    vt.push_back('{mk(5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0), DEF,   "no_hazard"});
    vt.push_back('{mk(5'd5, 5'd2, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0), STALL, "load_use_rs"});
    vt.push_back('{mk(5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0), STALL, "load_use_rt"});
    vt.push_back('{mk(5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0), DEF,   "load_rt_unused"});
    vt.push_back('{mk(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0), DEF,   "load_r0"});
    vt.push_back('{mk(5'd4, 5'd1, 1'b1, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0), STALL, "alu_branch_rs"});
    vt.push_back('{mk(5'd1, 5'd4, 1'b0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0), DEF,   "alu_branch_rt_unused"});
    vt.push_back('{mk(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0), DEF,   "alu_branch_r0"});
    vt.push_back('{mk(5'd4, 5'd1, 1'b1, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0), DEF,   "alu_nonbranch_dep"});
    vt.push_back('{mk(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0), FLUSH, "taken_clean"});
    vt.push_back('{mk(5'd4, 5'd2, 1'b1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0), STALL, "taken_during_stall"});
    vt.push_back('{mk(5'd4, 5'd2, 1'b1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1, 1'b1), MD,    "muldiv_priority"});
    vt.push_back('{mk(5'd3, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0), STALL, "load_branch"});

    do_reset("reset_outputs");
    check_val("reset_stall_cnt", int'(stall_cycles), 0);
    check_val("reset_flush_cnt", int'(flush_count), 0);

    foreach (vt[i]) begin
      do_reset("vec_reset");
      step(vt[i].in, vt[i].ctl, vt[i].name);
      check_val({vt[i].name, "_stall_cnt"}, int'(stall_cycles), vt[i].ctl[5] ? 0 : 1);
      check_val({vt[i].name, "_flush_cnt"}, int'(flush_count), vt[i].ctl[3] ? 1 : 0);
    end

    // Load-use: one bubble, then the bubble in EX clears the hazard.
    do_reset("seq_lu_reset");
    step(lu, STALL, "lu_stall");
    step(mk(5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0), DEF, "lu_resume");
    check_val("lu_stall_cnt", int'(stall_cycles), 1);

    // Load feeding a taken branch: RUN stall, BR_HOLD stall, then the flush.
    do_reset("seq_lb_reset");
    step(mk(5'd3, 5'd0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0), STALL, "lb_run_stall");
    step(mk(5'd3, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0), STALL, "lb_hold_stall");
    step(mk(5'd3, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0), FLUSH, "lb_flush");
    check_val("lb_stall_cnt", int'(stall_cycles), 2);
    check_val("lb_flush_cnt", int'(flush_count), 1);

    // Mul/div occupancy; a taken branch in the release cycle must flush.
    do_reset("seq_md_reset");
    step(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1), MD, "md_entry");
    step(mk(5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1), MD, "md_wait1");
    step(mk(5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1), MD, "md_wait2");
    step(mk(5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1), FLUSH, "md_release");
    check_val("md_stall_cnt", int'(stall_cycles), 3);
    check_val("md_flush_cnt", int'(flush_count), 1);
    step(idle, DEF, "md_after");
    check_val("md_stall_cnt_after", int'(stall_cycles), 3);

    // Reset asserted in the second MD_WAIT cycle.
    do_reset("seq_rm_reset");
    step(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1), MD, "rm_entry");
    step(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1), MD, "rm_wait1");
    reset = 1'b1;
    #1;
    sb.push_back('{RST, "rm_async_outputs"});
    check_ctl();
    check_val("rm_async_stall_cnt", int'(stall_cycles), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_val("rm_post_stall_cnt", int'(stall_cycles), 0);
    check_val("rm_post_flush_cnt", int'(flush_count), 0);
    step(idle, DEF, "rm_run_default");
    step(lu, STALL, "rm_run_loaduse");

    // Saturation of the 4-bit stall counter.
    do_reset("seq_sat_reset");
    for (int i = 1; i <= 20; i++) begin
      step(lu, STALL, "sat_stall");
      check_val("sat_stall_cnt", int'(stall_cycles), (i > 15) ? 15 : i);
    end

    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
